// File: rtl/cpu_controller.sv
// ---------------------------------------------------------------------------
// cpu_controller
//
// Eight-phase instruction sequencer for the 8-bit RISC CPU. A 3-bit phase
// counter steps through fetch (ph0-3), operand (ph4-5) and execute (ph6-7).
// The control strobes are decoded combinationally from the phase, the
// instruction opcode and the ALU zero flag.
//
// Parameters
//   OPCODE_W     opcode width (encoding HLT=0 SKZ=1 ADD=2 AND=3 XOR=4
//                LDA=5 STO=6 JMP=7)
//   HALT_STICKY  1: HLT freezes the sequencer until reset
//                0: halt is a one-phase pulse and sequencing continues
//
// Ports
//   clk     in   system clock, rising edge
//   rst     in   asynchronous reset, active-high
//   opcode  in   IR opcode field, decoded live in ph4-7
//   zero    in   ALU is_zero flag, consulted in ph6 for SKZ
//   sel     out  address mux: 1 = PC, 0 = IR operand address
//   rd      out  memory read enable
//   ld_ir   out  load instruction register
//   inc_pc  out  increment program counter
//   halt    out  halt indication
//   ld_pc   out  load PC from IR operand (jump)
//   data_e  out  drive accumulator onto data bus
//   ld_ac   out  load accumulator from ALU result
//   wr      out  memory write strobe
//   phase   out  current phase number 0..7 (sequencer state)
//   halted  out  sticky halt flag
// ---------------------------------------------------------------------------
module cpu_controller #(
    parameter int OPCODE_W    = 3,
    parameter bit HALT_STICKY = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    output logic                sel,
    output logic                rd,
    output logic                ld_ir,
    output logic                inc_pc,
    output logic                halt,
    output logic                ld_pc,
    output logic                data_e,
    output logic                ld_ac,
    output logic                wr,
    output logic [2:0]          phase,
    output logic                halted
);

    localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_SKZ = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_AND = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_XOR = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_STO = OPCODE_W'(6);
    localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(7);

    typedef enum logic [2:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_t;

    phase_t r_phase;
    phase_t w_phase_next;
    logic   r_halted;
    logic   w_halted_next;

    logic   w_is_hlt;
    logic   w_is_skz;
    logic   w_is_sto;
    logic   w_is_jmp;
    logic   w_aluop;

    assign w_is_hlt = (opcode == OP_HLT);
    assign w_is_skz = (opcode == OP_SKZ);
    assign w_is_sto = (opcode == OP_STO);
    assign w_is_jmp = (opcode == OP_JMP);
    assign w_aluop  = (opcode == OP_ADD) || (opcode == OP_AND) ||
                      (opcode == OP_XOR) || (opcode == OP_LDA);

    // State register. Reset is asynchronous so that the ph0 decode (and the
    // removal of any in-flight wr/ld_ac/ld_pc) takes effect immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase  <= PH_INST_ADDR;
            r_halted <= 1'b0;
        end else begin
            r_phase  <= w_phase_next;
            r_halted <= w_halted_next;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        w_phase_next  = r_phase;
        w_halted_next = r_halted;
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        halt   = 1'b0;
        ld_pc  = 1'b0;
        data_e = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;

        if (r_halted) begin
            // Frozen: phase holds and only halt is asserted.
            halt = 1'b1;
        end else begin
            w_phase_next = phase_t'(r_phase + 3'd1);
            case (r_phase)
                PH_INST_ADDR: begin
                    sel = 1'b1;
                end
                PH_INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                PH_OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = w_is_hlt;
                    // Sticky halt latches on the edge that leaves ph4; the
                    // phase still advances to ph5 and then holds there.
                    if (HALT_STICKY && w_is_hlt) begin
                        w_halted_next = 1'b1;
                    end
                end
                PH_OP_FETCH: begin
                    rd = w_aluop;
                end
                PH_ALU_OP: begin
                    rd     = w_aluop;
                    inc_pc = w_is_skz && zero;
                    ld_pc  = w_is_jmp;
                    data_e = w_is_sto;
                end
                PH_STORE: begin
                    rd     = w_aluop;
                    ld_ac  = w_aluop;
                    ld_pc  = w_is_jmp;
                    wr     = w_is_sto;
                    data_e = w_is_sto;
                end
                default: begin
                    sel = 1'b0;
                end
            endcase
        end
    end

    assign phase  = r_phase;
    assign halted = r_halted;

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller. Instance a uses HALT_STICKY=1 and
// instance b uses HALT_STICKY=0; both share clock, reset and inputs.
// Strobe vectors are packed {sel,rd,ld_ir,inc_pc,halt,ld_pc,data_e,ld_ac,wr}.
module tb_cpu_controller;

  logic       clk;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;

  logic a_sel, a_rd, a_ld_ir, a_inc_pc, a_halt, a_ld_pc, a_data_e, a_ld_ac, a_wr, a_halted;
  logic b_sel, b_rd, b_ld_ir, b_inc_pc, b_halt, b_ld_pc, b_data_e, b_ld_ac, b_wr, b_halted;
  logic [2:0] a_phase, b_phase;
  logic [8:0] a_str, b_str;

  int checks;
  int failures;

  localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, AND_ = 3'd3,
                         XOR_ = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;

  // Hand-derived fetch-phase vectors, identical for every opcode.
  localparam logic [8:0] S_PH0  = 9'b100000000;
  localparam logic [8:0] S_PH1  = 9'b110000000;
  localparam logic [8:0] S_PH23 = 9'b111000000;
  localparam logic [8:0] S_NONE = 9'b000000000;

  assign a_str = {a_sel, a_rd, a_ld_ir, a_inc_pc, a_halt, a_ld_pc, a_data_e, a_ld_ac, a_wr};
  assign b_str = {b_sel, b_rd, b_ld_ir, b_inc_pc, b_halt, b_ld_pc, b_data_e, b_ld_ac, b_wr};

  cpu_controller #(.OPCODE_W(3), .HALT_STICKY(1'b1)) dut_a (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .sel(a_sel), .rd(a_rd), .ld_ir(a_ld_ir), .inc_pc(a_inc_pc), .halt(a_halt),
    .ld_pc(a_ld_pc), .data_e(a_data_e), .ld_ac(a_ld_ac), .wr(a_wr),
    .phase(a_phase), .halted(a_halted)
  );

  cpu_controller #(.OPCODE_W(3), .HALT_STICKY(1'b0)) dut_b (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .sel(b_sel), .rd(b_rd), .ld_ir(b_ld_ir), .inc_pc(b_inc_pc), .halt(b_halt),
    .ld_pc(b_ld_pc), .data_e(b_data_e), .ld_ac(b_ld_ac), .wr(b_wr),
    .phase(b_phase), .halted(b_halted)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Walk one full instruction from ph0 on both instances.
  task automatic run_instr(input string tag, input logic [2:0] op, input logic z,
                           input logic [8:0] e4, input logic [8:0] e5,
                           input logic [8:0] e6, input logic [8:0] e7);
    logic [8:0] e [8];
    e[0] = S_PH0; e[1] = S_PH1; e[2] = S_PH23; e[3] = S_PH23;
    e[4] = e4;    e[5] = e5;    e[6] = e6;     e[7] = e7;
    opcode = op;
    zero   = z;
    for (int p = 0; p < 8; p++) begin
      chk($sformatf("%s_a_phase%0d", tag, p), {6'd0, a_phase}, 9'(p));
      chk($sformatf("%s_a_str_ph%0d", tag, p), a_str, e[p]);
      chk($sformatf("%s_b_str_ph%0d", tag, p), b_str, e[p]);
      chk($sformatf("%s_a_halted_ph%0d", tag, p), {8'd0, a_halted}, 9'd0);
      step();
    end
  endtask

  initial begin
    int exp_b_ph;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    opcode   = HLT;
    zero     = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_a_phase", {6'd0, a_phase}, 9'd0);
    chk("rst_a_str", a_str, S_PH0);
    chk("rst_a_halted", {8'd0, a_halted}, 9'd0);
    chk("rst_b_str", b_str, S_PH0);
    rst = 1'b0;

    // 1: reset mid-ph6 of JMP aborts ld_pc immediately
    opcode = JMP;
    for (int i = 0; i < 6; i++) step();
    chk("jmp_pre_phase", {6'd0, a_phase}, 9'd6);
    chk("jmp_pre_ldpc", a_str, 9'b000001000);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_a_phase", {6'd0, a_phase}, 9'd0);
    chk("midrst_a_str", a_str, S_PH0);
    chk("midrst_b_str", b_str, S_PH0);
    step();
    chk("midrst_hold_phase", {6'd0, a_phase}, 9'd0);
    chk("midrst_hold_str", a_str, S_PH0);
    rst = 1'b0;

    // 2: ALU opcodes
    run_instr("add", ADD, 1'b0, 9'b000100000, 9'b010000000, 9'b010000000, 9'b010000010);
    run_instr("and", AND_, 1'b1, 9'b000100000, 9'b010000000, 9'b010000000, 9'b010000010);
    run_instr("xor", XOR_, 1'b0, 9'b000100000, 9'b010000000, 9'b010000000, 9'b010000010);
    run_instr("lda", LDA, 1'b1, 9'b000100000, 9'b010000000, 9'b010000000, 9'b010000010);

    // 3: SKZ taken / not taken
    run_instr("skz1", SKZ, 1'b1, 9'b000100000, S_NONE, 9'b000100000, S_NONE);
    run_instr("skz0", SKZ, 1'b0, 9'b000100000, S_NONE, S_NONE, S_NONE);

    // 4: STO and JMP
    run_instr("sto", STO, 1'b1, 9'b000100000, S_NONE, 9'b000000100, 9'b000000101);
    run_instr("jmp", JMP, 1'b0, 9'b000100000, S_NONE, 9'b000001000, 9'b000001000);

    // 5/6: HLT, sticky on a, pulse on b
    opcode = HLT;
    zero   = 1'b1;
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("hlt_a_str_ph%0d", p), a_str, (p == 0) ? S_PH0 : (p == 1) ? S_PH1 : S_PH23);
      step();
    end
    chk("hlt_a_phase4", {6'd0, a_phase}, 9'd4);
    chk("hlt_a_str_ph4", a_str, 9'b000110000);
    chk("hlt_b_str_ph4", b_str, 9'b000110000);
    step();
    exp_b_ph = 5;
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("halted_a_phase_k%0d", k), {6'd0, a_phase}, 9'd5);
      chk($sformatf("halted_a_str_k%0d", k), a_str, 9'b000010000);
      chk($sformatf("halted_a_flag_k%0d", k), {8'd0, a_halted}, 9'd1);
      chk($sformatf("pulse_b_phase_k%0d", k), {6'd0, b_phase}, 9'(exp_b_ph));
      chk($sformatf("pulse_b_halt_k%0d", k), {8'd0, b_halt}, (exp_b_ph == 4) ? 9'd1 : 9'd0);
      chk($sformatf("pulse_b_halted_k%0d", k), {8'd0, b_halted}, 9'd0);
      exp_b_ph = (exp_b_ph + 1) % 8;
      step();
    end

    // rst clears halted and restarts at ph0
    rst = 1'b1;
    #1;
    chk("unhalt_a_flag", {8'd0, a_halted}, 9'd0);
    chk("unhalt_a_phase", {6'd0, a_phase}, 9'd0);
    chk("unhalt_a_str", a_str, S_PH0);
    step();
    rst = 1'b0;
    run_instr("post_add", ADD, 1'b0, 9'b000100000, 9'b010000000, 9'b010000000, 9'b010000010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
